// File: rtl/load_store_unit.sv
// load_store_unit: memory stage between ALU and writeback, req/ready handshake to data memory.
// Define LSU_TIMEOUT_EN to add the ACCESS timeout counter (error code 11).
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_err,
    output logic [1:0]  lsu_err_code
);
    typedef enum logic {IDLE, ACCESS} state_t;

    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    state_t      state, state_n;
    logic        req_n, we_n, wb_valid_n, err_n;
    logic [31:0] addr_n, wdata_n, wb_data_n, load_val;
    logic [3:0]  wstrb_n;
    logic [4:0]  wb_rd_n, op_rd, op_rd_n;
    logic [2:0]  op_funct3, op_funct3_n;
    logic [1:0]  op_off, op_off_n, code_n;
    logic        illegal, misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt, cnt_n;
`endif

    assign ex_ready = (state == IDLE);

    always_comb begin
        illegal = (ex_mem_read && ex_mem_write)
               || (ex_mem_read && !(ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
               || (ex_mem_write && !(ex_funct3 inside {3'b000, 3'b001, 3'b010}));
        misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0])
                  || ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
    end

    // Byte/half lane picked from the latched low address bits of the access.
    always_comb begin
        byte_sel = 8'(mem_rdata >> {op_off, 3'b000});
        half_sel = 16'(mem_rdata >> {op_off[1], 4'b0000});
        case (op_funct3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_n     = state;
        req_n       = mem_req;
        we_n        = mem_we;
        addr_n      = mem_addr;
        wstrb_n     = mem_wstrb;
        wdata_n     = mem_wdata;
        wb_valid_n  = 1'b0;
        wb_rd_n     = wb_rd;
        wb_data_n   = wb_data;
        err_n       = 1'b0;
        code_n      = lsu_err_code;
        op_rd_n     = op_rd;
        op_funct3_n = op_funct3;
        op_off_n    = op_off;
`ifdef LSU_TIMEOUT_EN
        cnt_n       = cnt;
`endif
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_mem_read && !ex_mem_write) begin
                        wb_valid_n = 1'b1;
                        wb_rd_n    = ex_rd;
                        wb_data_n  = ex_addr;
                    end else if (illegal) begin
                        err_n  = 1'b1;
                        code_n = 2'b10;
                    end else if (misaligned) begin
                        err_n  = 1'b1;
                        code_n = 2'b01;
                    end else begin
                        state_n     = ACCESS;
                        req_n       = 1'b1;
                        we_n        = ex_mem_write;
                        addr_n      = {ex_addr[31:2], 2'b00};
                        op_rd_n     = ex_rd;
                        op_funct3_n = ex_funct3;
                        op_off_n    = ex_addr[1:0];
`ifdef LSU_TIMEOUT_EN
                        cnt_n       = '0;
`endif
                        if (ex_mem_write) begin
                            case (ex_funct3[1:0])
                                2'b00: begin
                                    wdata_n = {4{ex_wdata[7:0]}};
                                    wstrb_n = 4'(4'b0001 << ex_addr[1:0]);
                                end
                                2'b01: begin
                                    wdata_n = {2{ex_wdata[15:0]}};
                                    wstrb_n = 4'(4'b0011 << ex_addr[1:0]);
                                end
                                default: begin
                                    wdata_n = ex_wdata;
                                    wstrb_n = 4'b1111;
                                end
                            endcase
                        end else begin
                            wstrb_n = '0;
                        end
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    wstrb_n = '0;
                    if (!mem_we) begin
                        wb_valid_n = 1'b1;
                        wb_rd_n    = op_rd;
                        wb_data_n  = load_val;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    wstrb_n = '0;
                    err_n   = 1'b1;
                    code_n  = 2'b11;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wstrb    <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            lsu_err      <= 1'b0;
            lsu_err_code <= '0;
            op_rd        <= '0;
            op_funct3    <= '0;
            op_off       <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            state        <= state_n;
            mem_req      <= req_n;
            mem_we       <= we_n;
            mem_addr     <= addr_n;
            mem_wstrb    <= wstrb_n;
            mem_wdata    <= wdata_n;
            wb_valid     <= wb_valid_n;
            wb_rd        <= wb_rd_n;
            wb_data      <= wb_data_n;
            lsu_err      <= err_n;
            lsu_err_code <= code_n;
            op_rd        <= op_rd_n;
            op_funct3    <= op_funct3_n;
            op_off       <= op_off_n;
`ifdef LSU_TIMEOUT_EN
            cnt          <= cnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random ops against a memory model.
module tb_load_store_unit;
`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_ready, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, lsu_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  lsu_err_code;

    int passed = 0;
    int total = 0;
    logic [31:0] mem [64];

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lsu_err(lsu_err), .lsu_err_code(lsu_err_code)
    );

    // Reference model: 0 pass-through, 1 memory access, 2 illegal, 3 misaligned
    function automatic int m_class(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
        if (!rd && !wr) return 0;
        if (rd && wr) return 2;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2;
        if (wr && f3 > 3'd2) return 2;
        if (f3[1:0] == 2'd1 && (a % 2) != 0) return 3;
        if (f3[1:0] == 2'd2 && (a % 4) != 0) return 3;
        return 1;
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] w, logic [2:0] f3, int off);
        int b, h;
        b = int'((w >> (8 * off)) & 32'hFF);
        h = int'((w >> (8 * (off & 2))) & 32'hFFFF);
        case (f3)
            3'd0: return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd4: return 32'(b);
            3'd1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd5: return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(logic [2:0] f3, int off);
        int n;
        n = 1 << f3[1:0];
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [4:0] dst);
        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3;
        ex_addr = a; ex_wdata = wd; ex_rd = dst;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #2;
        total++;
        if ({mem_req, mem_we, mem_wstrb, wb_valid, lsu_err, lsu_err_code, ex_ready} !== 11'b1 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || wb_rd !== 5'h0 || wb_data !== 32'h0)
            $display("FAIL reset_state: req=%b we=%b strb=%h wbv=%b err=%b code=%b rdy=%b addr=%h wdata=%h wbrd=%0d wbdata=%h required all 0, ex_ready=1",
                     mem_req, mem_we, mem_wstrb, wb_valid, lsu_err, lsu_err_code, ex_ready, mem_addr, mem_wdata, wb_rd, wb_data);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        drive_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5);
        tick(); ex_valid = 1'b0;
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h0000_1234 || mem_req !== 1'b0)
            $display("FAIL passthrough: wbv=%b rd=%0d data=%h req=%b required 1/5/00001234/0", wb_valid, wb_rd, wb_data, mem_req);
        else passed++;
        tick();
        total++;
        if (wb_valid !== 1'b0) $display("FAIL passthrough_pulse: wb_valid=%b required 0", wb_valid);
        else passed++;
    endtask

    task automatic test_lb(input logic [2:0] f3, input logic [31:0] exp);
        logic ok;
        drive_op(1'b1, 1'b0, f3, 32'h0000_0103, 32'h0, 5'd9);
        tick(); ex_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0100 ||
                mem_wstrb !== 4'h0 || ex_ready !== 1'b0) ok = 1'b0;
            tick();
        end
        total++;
        if (!ok || mem_req !== 1'b1 || ex_ready !== 1'b0)
            $display("FAIL lb_access f3=%0d: req=%b addr=%h rdy=%b required req=1 addr=00000100 ex_ready=0 throughout", f3, mem_req, mem_addr, ex_ready);
        else passed++;
        mem_ready = 1'b1; mem_rdata = 32'h80FF_FFFF;
        tick(); mem_ready = 1'b0; mem_rdata = $urandom;
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== exp || mem_req !== 1'b0 || ex_ready !== 1'b1)
            $display("FAIL lb_wb f3=%0d: wbv=%b rd=%0d data=%h req=%b required 1/9/%h/0", f3, wb_valid, wb_rd, wb_data, mem_req, exp);
        else passed++;
    endtask

    task automatic test_sh();
        drive_op(1'b0, 1'b1, 3'd1, 32'h0000_0012, 32'hDEAD_BEEF, 5'd3);
        tick(); ex_valid = 1'b0;
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b1100 ||
            mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h0000_0010)
            $display("FAIL sh_req: req=%b we=%b strb=%b wdata=%h addr=%h required 1/1/1100/beefbeef/00000010",
                     mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr);
        else passed++;
        mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        total++;
        if (wb_valid !== 1'b0 || mem_req !== 1'b0 || lsu_err !== 1'b0)
            $display("FAIL sh_done: wbv=%b req=%b err=%b required 0/0/0", wb_valid, mem_req, lsu_err);
        else passed++;
    endtask

    task automatic test_errors();
        drive_op(1'b1, 1'b0, 3'd2, 32'h0000_0006, 32'h0, 5'd4);
        tick(); ex_valid = 1'b0;
        total++;
        if (lsu_err !== 1'b1 || lsu_err_code !== 2'b01 || mem_req !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL misaligned_lw: err=%b code=%b req=%b wbv=%b required 1/01/0/0", lsu_err, lsu_err_code, mem_req, wb_valid);
        else passed++;
        tick();
        total++;
        if (lsu_err !== 1'b0 || lsu_err_code !== 2'b01 || mem_req !== 1'b0)
            $display("FAIL err_pulse_hold: err=%b code=%b req=%b required 0/01/0", lsu_err, lsu_err_code, mem_req);
        else passed++;
        drive_op(1'b1, 1'b1, 3'd2, 32'h0000_0008, 32'h0, 5'd4);
        tick(); ex_valid = 1'b0;
        total++;
        if (lsu_err !== 1'b1 || lsu_err_code !== 2'b10 || mem_req !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL illegal_rw: err=%b code=%b req=%b wbv=%b required 1/10/0/0", lsu_err, lsu_err_code, mem_req, wb_valid);
        else passed++;
        drive_op(1'b0, 1'b1, 3'd4, 32'h0000_0008, 32'h0, 5'd4);
        tick(); ex_valid = 1'b0;
        total++;
        if (lsu_err !== 1'b1 || lsu_err_code !== 2'b10 || mem_req !== 1'b0)
            $display("FAIL illegal_store_f3: err=%b code=%b req=%b required 1/10/0", lsu_err, lsu_err_code, mem_req);
        else passed++;
        tick();
    endtask

    task automatic test_timeout();
        int held;
        drive_op(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 5'd7);
        tick(); ex_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
        held = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_req === 1'b1 && lsu_err === 1'b0) held++;
        end
        total++;
        if (held != 3) $display("FAIL timeout_hold: req held %0d cycles, required 3", held);
        else passed++;
        tick();
        total++;
        if (mem_req !== 1'b0 || lsu_err !== 1'b1 || lsu_err_code !== 2'b11 || ex_ready !== 1'b1 || wb_valid !== 1'b0)
            $display("FAIL timeout_fire: req=%b err=%b code=%b rdy=%b wbv=%b required 0/1/11/1/0",
                     mem_req, lsu_err, lsu_err_code, ex_ready, wb_valid);
        else passed++;
        tick();
        total++;
        if (lsu_err !== 1'b0 || lsu_err_code !== 2'b11)
            $display("FAIL timeout_pulse: err=%b code=%b required 0/11", lsu_err, lsu_err_code);
        else passed++;
`else
        held = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mem_req === 1'b1 && ex_ready === 1'b0 && lsu_err === 1'b0) held++;
        end
        total++;
        if (held != 100) $display("FAIL no_timeout: req held %0d cycles, required 100", held);
        else passed++;
        mem_ready = 1'b1; mem_rdata = 32'h1357_9BDF;
        tick(); mem_ready = 1'b0;
        total++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h1357_9BDF || wb_rd !== 5'd7 || mem_req !== 1'b0)
            $display("FAIL no_timeout_wb: wbv=%b data=%h rd=%0d req=%b required 1/13579bdf/7/0", wb_valid, wb_data, wb_rd, mem_req);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid_access();
        drive_op(1'b1, 1'b0, 3'd2, 32'h0000_0080, 32'h0, 5'd2);
        tick(); ex_valid = 1'b0;
        tick();
        rst_n = 1'b0; #1;
        total++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b0 || lsu_err !== 1'b0)
            $display("FAIL reset_mid_access: req=%b wbv=%b err=%b required 0/0/0", mem_req, wb_valid, lsu_err);
        else passed++;
        mem_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick(); mem_ready = 1'b0;
        total++;
        if (ex_ready !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0 || lsu_err !== 1'b0)
            $display("FAIL reset_release: rdy=%b req=%b wbv=%b err=%b required 1/0/0/0", ex_ready, mem_req, wb_valid, lsu_err);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            drive_op(1'b0, 1'b0, 3'($urandom_range(0, 7)), v, $urandom, 5'(i + 10));
            tick();
            total++;
            if (wb_valid !== 1'b1 || wb_rd !== 5'(i + 10) || wb_data !== v || mem_req !== 1'b0 || ex_ready !== 1'b1)
                $display("FAIL back_to_back[%0d]: wbv=%b rd=%0d data=%h req=%b required 1/%0d/%h/0", i, wb_valid, wb_rd, wb_data, mem_req, i + 10, v);
            else passed++;
        end
        ex_valid = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_random(input int n);
        logic [2:0]  legal_ld [5];
        logic        rdq, wrq;
        logic [2:0]  f3;
        logic [31:0] a, wd, exp_wd, exp_ld, held_addr;
        logic [3:0]  exp_strb;
        logic [4:0]  dst;
        int k, cls, idx, off, d;
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            rdq = (k >= 2 && k <= 5) || k == 9;
            wrq = (k >= 6);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (rdq) f3 = legal_ld[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            a = $urandom; wd = $urandom; dst = 5'($urandom);
            cls = m_class(rdq, wrq, f3, a);
            idx = int'(a[7:2]); off = int'(a[1:0]);
            drive_op(rdq, wrq, f3, a, wd, dst);
            total++;
            if (ex_ready !== 1'b1) $display("FAIL rnd_ready[%0d]: ex_ready=%b required 1", i, ex_ready);
            else passed++;
            tick(); ex_valid = 1'b0;
            if (cls == 0) begin
                total++;
                if (wb_valid !== 1'b1 || wb_rd !== dst || wb_data !== a || mem_req !== 1'b0)
                    $display("FAIL rnd_pass[%0d]: wbv=%b rd=%0d data=%h required 1/%0d/%h", i, wb_valid, wb_rd, wb_data, dst, a);
                else passed++;
            end else if (cls >= 2) begin
                total++;
                if (lsu_err !== 1'b1 || lsu_err_code !== ((cls == 2) ? 2'b10 : 2'b01) || mem_req !== 1'b0 || wb_valid !== 1'b0)
                    $display("FAIL rnd_err[%0d]: err=%b code=%b req=%b class=%0d", i, lsu_err, lsu_err_code, mem_req, cls);
                else passed++;
            end else begin
                exp_strb = wrq ? m_strb(f3, off) : 4'h0;
                exp_wd = m_wdata(f3, wd);
                total++;
                if (mem_req !== 1'b1 || mem_we !== wrq || mem_addr !== {a[31:2], 2'b00} || mem_wstrb !== exp_strb ||
                    (wrq && mem_wdata !== exp_wd))
                    $display("FAIL rnd_req[%0d]: req=%b we=%b addr=%h strb=%b wdata=%h required 1/%b/%h/%b/%h",
                             i, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, wrq, {a[31:2], 2'b00}, exp_strb, exp_wd);
                else passed++;
                held_addr = mem_addr;
                d = $urandom_range(0, 3);
                for (int j = 0; j < d; j++) begin
                    mem_rdata = $urandom;
                    tick();
                    total++;
                    if (mem_req !== 1'b1 || ex_ready !== 1'b0 || mem_addr !== held_addr || wb_valid !== 1'b0)
                        $display("FAIL rnd_wait[%0d]: req=%b rdy=%b addr=%h wbv=%b required 1/0/%h/0", i, mem_req, ex_ready, mem_addr, wb_valid, held_addr);
                    else passed++;
                end
                mem_ready = 1'b1; mem_rdata = mem[idx];
                exp_ld = m_load(mem[idx], f3, off);
                tick(); mem_ready = 1'b0; mem_rdata = $urandom;
                if (wrq) begin
                    for (int b = 0; b < 4; b++) if (exp_strb[b]) mem[idx][8*b +: 8] = exp_wd[8*b +: 8];
                    total++;
                    if (wb_valid !== 1'b0 || mem_req !== 1'b0 || lsu_err !== 1'b0)
                        $display("FAIL rnd_store_done[%0d]: wbv=%b req=%b err=%b required 0/0/0", i, wb_valid, mem_req, lsu_err);
                    else passed++;
                end else begin
                    total++;
                    if (wb_valid !== 1'b1 || wb_rd !== dst || wb_data !== exp_ld || mem_req !== 1'b0)
                        $display("FAIL rnd_load[%0d]: wbv=%b rd=%0d data=%h required 1/%0d/%h (f3=%0d off=%0d)",
                                 i, wb_valid, wb_rd, wb_data, dst, exp_ld, f3, off);
                    else passed++;
                end
            end
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        test_reset();
        test_passthrough();
        test_lb(3'd0, 32'hFFFF_FF80);
        test_lb(3'd4, 32'h0000_0080);
        test_sh();
        test_errors();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random(300);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
